// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider: per-channel runtime divisor, glitch-free at period boundaries.
// Optional phase-align input `sync` is built only when CLKDIV_SYNC_EN is defined.
module clk_divider_prog #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 20,
  parameter int DEFAULT_DIV = 10000,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] s_q   [NCH];
  logic [WIDTH-1:0] d_q   [NCH];
  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] s_d   [NCH];
  logic [WIDTH-1:0] d_d   [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  logic [NCH-1:0]   out_q, out_d;
  logic [NCH-1:0]   tick_q, tick_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      s_d[i]    = s_q[i];
      d_d[i]    = d_q[i];
      cnt_d[i]  = cnt_q[i];
      out_d[i]  = out_q[i];
      tick_d[i] = 1'b0;

      // Indices with no channel (wr_ch >= NCH) match no i and are dropped.
      if (wr_en && (wr_ch == CHW'(i))) begin
        s_d[i] = wr_div;
      end

`ifdef CLKDIV_SYNC_EN
      if (sync) begin
        d_d[i]    = s_q[i];
        cnt_d[i]  = '0;
        out_d[i]  = (s_q[i] >= TWO);
        tick_d[i] = (s_q[i] >= TWO);
      end else
`endif
      if (en) begin
        if (d_q[i] >= TWO) begin
          if (cnt_q[i] == d_q[i] - ONE) begin
            cnt_d[i] = '0;
            d_d[i]   = s_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
          // High phase uses the divisor in force for the new count.
          out_d[i]  = (cnt_d[i] < (d_d[i] >> 1));
          tick_d[i] = (cnt_d[i] == '0);
        end else begin
          // Stopped: keep preloading so the next wrap check starts a fresh period.
          d_d[i]    = s_q[i];
          cnt_d[i]  = s_q[i] - ONE;
          out_d[i]  = 1'b0;
          tick_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        s_q[i]   <= DEF_DIV;
        d_q[i]   <= DEF_DIV;
        cnt_q[i] <= DEF_DIV - ONE;
      end
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s_q[i]   <= s_d[i];
        d_q[i]   <= d_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog (NCH=4, WIDTH=20, DEFAULT_DIV=10000).
// Edge numbers count rising edges since reset release; outputs sampled 1 time unit after each edge.
module tb_clk_divider_prog;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [19:0] wr_div;
`ifdef CLKDIV_SYNC_EN
  logic        sync;
`endif
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  clk_divider_prog #(.NCH(4), .WIDTH(20), .DEFAULT_DIV(10000)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .clk_out (clk_out),
    .tick    (tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int edge_n  = 0;
  int hi_c [4];
  int tk_c [4];
  logic [3:0] tick_or;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_until(input int e);
    while (edge_n < e) step();
  endtask

  task automatic write_at(input int e, input int ch, input int div);
    run_until(e - 1);
    wr_en  = 1'b1;
    wr_ch  = 2'(ch);
    wr_div = 20'(div);
    step();
    wr_en  = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      hi_c[i] = 0;
      tk_c[i] = 0;
    end
    tick_or = '0;
  endtask

  task automatic accum();
    for (int i = 0; i < 4; i++) begin
      hi_c[i] += int'(clk_out[i]);
      tk_c[i] += int'(tick[i]);
    end
    tick_or |= tick;
  endtask

  // counts cover edges [current edge, last]
  task automatic run_window(input int last);
    clear_counts();
    accum();
    while (edge_n < last) begin
      step();
      accum();
    end
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b1;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync   = 1'b0;
`endif
    #3;
    check("reset_clk_out", 32'(clk_out), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;

    // default 10000: first edge ticks, 5000 high / 5000 low
    step();
    check("first_edge_clk_out", 32'(clk_out), 32'hf);
    check("first_edge_tick", 32'(tick), 32'hf);
    run_window(10000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("def_high_ch%0d", i), 32'(hi_c[i]), 32'd5000);
      check($sformatf("def_ticks_ch%0d", i), 32'(tk_c[i]), 32'd1);
    end
    step();
    check("second_period_tick", 32'(tick), 32'hf);

    // mid-period writes: ch1=7, ch2=0, ch0=6; all wait for the 20001 wrap
    write_at(10100, 1, 7);
    write_at(10101, 2, 0);
    write_at(10102, 0, 6);
    run_until(15000);
    check("old_period_high_end", 32'(clk_out), 32'hf);
    step();
    check("old_period_low_start", 32'(clk_out), 32'h0);
    run_until(20000);
    check("old_period_last", 32'(clk_out), 32'h0);
    step();
    check("wrap_new_div_clk_out", 32'(clk_out), 32'b1011);
    check("wrap_new_div_tick", 32'(tick & 4'b1011), 32'b1011);

    // ch1 at D=7: cnt 2 high, cnt 3 low
    run_until(20003);
    check("d7_cnt2_high", 32'(clk_out[1]), 32'd1);
    step();
    check("d7_cnt3_low", 32'(clk_out[1]), 32'd0);

    // ch0 write 9 on its wrap edge: one more 6-cycle period first
    write_at(20007, 0, 9);
    check("ww_edge_tick", 32'(tick), 32'b0001);
    check("ww_edge_clk_out", 32'(clk_out), 32'b1001);
    step();
    run_window(20012);
    check("ww_no_early_tick_ch0", 32'(tk_c[0]), 32'd0);
    check("d7_tick_ch1", 32'(tk_c[1]), 32'd1);
    step();
    check("ww_6cycle_tick_ch0", 32'(tick[0]), 32'd1);
    run_window(20021);
    check("d9_high_ch0", 32'(hi_c[0]), 32'd4);
    check("d9_ticks_ch0", 32'(tk_c[0]), 32'd1);
    check("d7_high_ch1", 32'(hi_c[1]), 32'd3);
    step();
    check("d9_next_tick_ch0", 32'(tick[0]), 32'd1);

    // ch2 stopped, restart with D=4: rises two edges after the write
    write_at(20030, 2, 4);
    step();
    check("restart_still_low", 32'(clk_out[2]), 32'd0);
    step();
    check("restart_rise", 32'(clk_out[2]), 32'd1);
    check("restart_tick", 32'(tick[2]), 32'd1);
    run_window(20035);
    check("d4_high_ch2", 32'(hi_c[2]), 32'd2);
    step();
    check("d4_tick_ch2", 32'(tick[2]), 32'd1);

    // ch2 to D=10, then freeze 50 edges inside its high phase
    write_at(20041, 2, 10);
    run_until(20043);
    step();
    check("d10_start_tick", 32'(tick[2]), 32'd1);
    clear_counts();
    accum();
    step(); accum();
    step(); accum();
    en = 1'b0;
    tick_or = '0;
    for (int k = 0; k < 50; k++) begin
      step();
      accum();
    end
    check("freeze_tick_zero", 32'(tick_or), 32'h0);
    en = 1'b1;
    while (edge_n < 20103) begin
      step();
      accum();
    end
    check("freeze_high_ch2", 32'(hi_c[2]), 32'd55);
    check("freeze_ticks_ch2", 32'(tk_c[2]), 32'd1);
    step();
    check("freeze_60cycle_tick", 32'(tick[2]), 32'd1);

    // async reset mid-period, pending write lost
    wr_en  = 1'b1;
    wr_ch  = 2'd1;
    wr_div = 20'd3;
    step();
    wr_en = 1'b0;
    rst   = 1'b0;
    #1;
    check("async_reset_clk_out", 32'(clk_out), 32'h0);
    check("async_reset_tick", 32'(tick), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;
    step();
    check("rerelease_clk_out", 32'(clk_out), 32'hf);
    check("rerelease_tick", 32'(tick), 32'hf);
    run_until(4);
    check("rerelease_default_div", 32'(clk_out), 32'hf);
    check("rerelease_no_tick", 32'(tick), 32'h0);

`ifdef CLKDIV_SYNC_EN
    write_at(5, 0, 6);
    write_at(6, 1, 9);
    write_at(7, 2, 10);
    run_until(20);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick_all", 32'(tick), 32'hf);
    check("sync_clk_out_all", 32'(clk_out), 32'hf);
    run_until(26);
    check("sync_quiet", 32'(tick), 32'h0);
    step();
    check("sync_ch0_period6", 32'(tick), 32'b0001);
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
